message_scroller: RTL and testbench

- Sits between the button pulse stage (debouncer → button_to_pulse) and the seg7 decoder in tt_um_seven_segment_fun1.
- Steps through a fixed 16-nibble message and presents the current nibble to seg7 as a 4-bit hex code.
- Advances either on single-cycle button pulses (MANUAL mode) or from an internal prescaled timer (AUTO mode).
- Emits a one-cycle step strobe on every advance for downstream effect logic.

---
 rtl/message_scroller.sv | 137 +++++++++++++
 tb/tb_message_scroller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_scroller.sv
// Steps through a fixed 16-nibble message for the seven-segment decoder.
// Advances on button pulses (MANUAL) or from a prescaled timer (AUTO).
module message_scroller #(
  parameter int CLK_DIV = 1000000,
  parameter int MSG_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next_pulse,
  input  logic       mode_pulse,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic [3:0] digit,
  output logic       dp,
  output logic [3:0] idx,
  output logic       auto_mode,
  output logic       step
);

  localparam int         CW   = $clog2(CLK_DIV);
  localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_s;
  logic            advance_s;
  logic [3:0]      idx_s;
  logic [31:0]     period_m1_s;
  logic            terminal_s;

  function automatic logic [3:0] rom_nibble(input logic [3:0] i);
    case (i)
      4'd0:    rom_nibble = 4'hD;
      4'd1:    rom_nibble = 4'hE;
      4'd2:    rom_nibble = 4'hA;
      4'd3:    rom_nibble = 4'hD;
      4'd4:    rom_nibble = 4'hB;
      4'd5:    rom_nibble = 4'hE;
      4'd6:    rom_nibble = 4'hE;
      4'd7:    rom_nibble = 4'hF;
      4'd8:    rom_nibble = 4'hC;
      4'd9:    rom_nibble = 4'hA;
      4'd10:   rom_nibble = 4'hF;
      4'd11:   rom_nibble = 4'hE;
      4'd12:   rom_nibble = 4'h0;
      4'd13:   rom_nibble = 4'h1;
      4'd14:   rom_nibble = 4'h2;
      4'd15:   rom_nibble = 4'h3;
      default: rom_nibble = 4'hD;
    endcase
  endfunction

  // Terminal detect uses >= so a speed change to a shorter period fires on the next edge.
  always_comb begin
    period_m1_s = (32'(CLK_DIV) >> speed) - 32'd1;
    terminal_s  = (32'(count_r) >= period_m1_s);
  end

  // Next-state: mode toggle wins over any advance; manual skip wins over the timer.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    advance_s = 1'b0;
    case (state_r)
      MANUAL: begin
        count_s = '0;
        if (mode_pulse) begin
          state_s = AUTO;
        end else begin
          advance_s = next_pulse;
        end
      end
      AUTO: begin
        if (mode_pulse) begin
          state_s = MANUAL;
          count_s = '0;
        end else if (next_pulse) begin
          advance_s = 1'b1;
          count_s   = '0;
        end else if (hold) begin
          count_s = count_r;
        end else if (terminal_s) begin
          advance_s = 1'b1;
          count_s   = '0;
        end else begin
          count_s = count_r + CW'(1);
        end
      end
      default: begin
        state_s = MANUAL;
        count_s = '0;
      end
    endcase
  end

  // Index wrap at the last used message position.
  always_comb begin
    idx_s = idx;
    if (advance_s) begin
      if (idx == LAST) begin
        idx_s = 4'd0;
      end else begin
        idx_s = idx + 4'd1;
      end
    end else begin
      idx_s = idx;
    end
  end

  // digit/dp are looked up from idx_s so they land on the same edge as idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MANUAL;
      count_r   <= '0;
      idx       <= 4'd0;
      digit     <= 4'hD;
      dp        <= 1'b0;
      auto_mode <= 1'b0;
      step      <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      idx       <= idx_s;
      digit     <= rom_nibble(idx_s);
      dp        <= (idx_s == LAST);
      auto_mode <= (state_s == AUTO);
      step      <= advance_s;
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
// Scoreboard bench for message_scroller: a 16-long and a 4-long instance share
// stimulus; a position/mode reference model predicts each cycle's outputs.
module tb_message_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_pulse = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] speed = 2'd0;

  logic [3:0] digit16, idx16, digit4, idx4;
  logic       dp16, auto16, step16, dp4, auto4, step4;

  always #5 clk = ~clk;

  message_scroller #(.CLK_DIV(8), .MSG_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .next_pulse(next_pulse), .mode_pulse(mode_pulse),
    .hold(hold), .speed(speed), .digit(digit16), .dp(dp16), .idx(idx16),
    .auto_mode(auto16), .step(step16)
  );

  message_scroller #(.CLK_DIV(8), .MSG_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .next_pulse(next_pulse), .mode_pulse(mode_pulse),
    .hold(hold), .speed(speed), .digit(digit4), .dp(dp4), .idx(idx4),
    .auto_mode(auto4), .step(step4)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] digit;
    logic       dp;
    logic       am;
    logic       st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int assertions = 0;
  int failures   = 0;

  logic [3:0] msg [16] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF,
                           4'hC, 4'hA, 4'hF, 4'hE, 4'h0, 4'h1, 4'h2, 4'h3};
  int lens [2] = '{16, 4};
  int m_auto [2];
  int m_cnt  [2];
  int m_pos  [2];
  logic [1:0] sp_cur = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_auto[k] = 0;
      m_cnt[k]  = 0;
      m_pos[k]  = 0;
    end
  endtask

  // One clock of the reference model for the inputs now on the pins.
  task automatic model_cycle();
    int period;
    int adv;
    exp_t e;
    period = 8 >> speed;
    for (int k = 0; k < 2; k++) begin
      adv = 0;
      if (mode_pulse) begin
        m_auto[k] = 1 - m_auto[k];
        m_cnt[k]  = 0;
      end else if (m_auto[k] == 0) begin
        adv = int'(next_pulse);
      end else if (next_pulse) begin
        adv = 1;
        m_cnt[k] = 0;
      end else if (!hold) begin
        if (m_cnt[k] + 1 >= period) begin
          adv = 1;
          m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      if (adv != 0) m_pos[k] = (m_pos[k] + 1) % lens[k];
      e.idx   = 4'(m_pos[k]);
      e.digit = msg[m_pos[k]];
      e.dp    = (m_pos[k] == lens[k] - 1);
      e.am    = (m_auto[k] != 0);
      e.st    = (adv != 0);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drive(input logic np, input logic mp, input logic h, input logic [1:0] sp);
    @(negedge clk);
    next_pulse = np;
    mode_pulse = mp;
    hold       = h;
    speed      = sp;
    model_cycle();
  endtask

  task automatic idle(input int n, input logic [1:0] sp);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, sp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    next_pulse = 1'b0;
    mode_pulse = 1'b0;
    hold = 1'b0;
    #1;
    chk("rst_idx16",   32'(idx16),   32'h0);
    chk("rst_digit16", 32'(digit16), 32'hD);
    chk("rst_dp16",    32'(dp16),    32'h0);
    chk("rst_auto16",  32'(auto16),  32'h0);
    chk("rst_step16",  32'(step16),  32'h0);
    chk("rst_idx4",    32'(idx4),    32'h0);
    chk("rst_auto4",   32'(auto4),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_cycle();
  endtask

  // Monitor: compare each DUT's registered outputs against the queued prediction.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        chk("idx16",   32'(idx16),   32'(e.idx));
        chk("digit16", 32'(digit16), 32'(e.digit));
        chk("dp16",    32'(dp16),    32'(e.dp));
        chk("auto16",  32'(auto16),  32'(e.am));
        chk("step16",  32'(step16),  32'(e.st));
      end
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("idx4",   32'(idx4),   32'(e.idx));
        chk("digit4", 32'(digit4), 32'(e.digit));
        chk("dp4",    32'(dp4),    32'(e.dp));
        chk("auto4",  32'(auto4),  32'(e.am));
        chk("step4",  32'(step4),  32'(e.st));
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Reset in the middle of an AUTO count, then idle.
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    idle(5, 2'd0);
    do_reset();
    idle(8, 2'd0);

    // MANUAL walk through the whole message and wrap.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      idle(2, 2'd0);
    end

    // AUTO at speed 0, then speed 3 (advance every cycle).
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    idle(20, 2'd0);
    idle(10, 2'd3);

    // Hold freezes the prescaler; a skip during hold still advances.
    idle(3, 2'd0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 2'd0);
    idle(10, 2'd0);

    // Count to 6, then shorten the period to 2.
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    idle(6, 2'd0);
    idle(7, 2'd2);

    // Mode toggle coinciding with a skip, from MANUAL and from AUTO.
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    idle(7, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    idle(2, 2'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sp_cur = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 23) == 0),
              1'($urandom_range(0, 5) == 0), sp_cur);
      end
    end

    idle(1, sp_cur);
    @(negedge clk);
    chk("q16_drained", 32'(q0.size()), 32'h0);
    chk("q4_drained",  32'(q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
